// File: rtl/dpram_arb_pkg.sv
// Shared FSM state type, default geometry and small helpers for the
// two-requester DPRAM port-0 arbiter.
package dpram_arb_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 16;
    localparam int NUM_REQ        = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    // One-hot grant to requester index; only meaningful for a non-zero grant.
    function automatic logic oh_to_idx(input logic [NUM_REQ-1:0] oh);
        return oh[1];
    endfunction

endpackage

// File: rtl/dpram_rr_pick.sv
// Two-way winner select: a lone requester always wins; on contention the
// requester named by ptr wins.
module dpram_rr_pick
    import dpram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = req;
        if (&req) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// Serialises two requesters onto DPRAM port 0 with an IDLE/SERVE/DONE FSM.
// Define DPRAM_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int addr_width = ADDR_WIDTH_DEF,
    parameter int depth      = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [2*addr_width-1:0]   addr,
    input  logic [2*data_width-1:0]   wdata,
    output logic [NUM_REQ-1:0]        ack,
    output logic [data_width-1:0]     rdata,
    output logic                      ram_port_en_0,
    output logic                      ram_wr_en,
    output logic [addr_width-1:0]     ram_addr_0,
    output logic [data_width-1:0]     ram_data_in,
    input  logic [data_width-1:0]     ram_data_out_0
);

    typedef struct packed {
        logic                  we;
        logic [addr_width-1:0] addr;
        logic [data_width-1:0] wdata;
    } acc_req_t;

    localparam logic [addr_width:0] DEPTH_LIM = (addr_width+1)'(depth);

    acc_req_t [NUM_REQ-1:0] lane_req;
    acc_req_t               cur_q;
    arb_state_e             state_q;
    logic [NUM_REQ-1:0]     win_q;
    logic [NUM_REQ-1:0]     grant;
    logic                   ptr;
    logic                   in_range;
    logic                   serve_live;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane_req[i].we    = we[i];
        assign lane_req[i].addr  = addr[i*addr_width +: addr_width];
        assign lane_req[i].wdata = wdata[i*data_width +: data_width];
    end

`ifdef DPRAM_ARB_FIXED_PRIO_EN
    assign ptr = 1'b0;
`else
    // ptr names the requester favoured on the next contention: the last loser.
    logic ptr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (state_q == IDLE && |req) begin
            ptr_q <= ~oh_to_idx(grant);
        end
    end
    assign ptr = ptr_q;
`endif

    dpram_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    // rst is folded in combinationally so a reset landing in SERVE cannot write.
    assign in_range      = {1'b0, cur_q.addr} < DEPTH_LIM;
    assign serve_live    = (state_q == SERVE) && !rst;
    assign ram_port_en_0 = serve_live && in_range;
    assign ram_wr_en     = serve_live && in_range && cur_q.we;
    assign ram_addr_0    = serve_live ? cur_q.addr  : '0;
    assign ram_data_in   = serve_live ? cur_q.wdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            win_q   <= '0;
            ack     <= '0;
            rdata   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack <= '0;
                    if (|req) begin
                        state_q <= SERVE;
                        win_q   <= grant;
                        cur_q   <= lane_req[oh_to_idx(grant)];
                    end
                end
                SERVE: begin
                    state_q <= DONE;
                    ack     <= win_q;
                    if (!cur_q.we) begin
                        rdata <= in_range ? ram_data_out_0 : '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ack     <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    ack     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Bench for dpram_arbiter: directed scenarios then random two-requester
// traffic, checked every cycle against a transaction-level model.
module tb_dpram_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 12;
    localparam int WORDS = 1 << AW;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            ram_init = 1'b1;
    logic [1:0]      req      = '0;
    logic [1:0]      we       = '0;
    logic [2*AW-1:0] addr     = '0;
    logic [2*DW-1:0] wdata    = '0;
    logic [1:0]      ack;
    logic [DW-1:0]   rdata;
    logic            ram_port_en_0;
    logic            ram_wr_en;
    logic [AW-1:0]   ram_addr_0;
    logic [DW-1:0]   ram_data_in;
    logic [DW-1:0]   ram_data_out_0;

    always #5 clk = ~clk;

    dpram_arbiter #(.data_width(DW), .addr_width(AW), .depth(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .ack            (ack),
        .rdata          (rdata),
        .ram_port_en_0  (ram_port_en_0),
        .ram_wr_en      (ram_wr_en),
        .ram_addr_0     (ram_addr_0),
        .ram_data_in    (ram_data_in),
        .ram_data_out_0 (ram_data_out_0)
    );

    function automatic logic [DW-1:0] init_val(input int i);
        return DW'(i * 37 + 11);
    endfunction

    // RAM device on port 0: synchronous write, asynchronous read.
    logic [DW-1:0] ram [0:WORDS-1];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < WORDS; i++) ram[i] <= init_val(i);
        end else if (ram_port_en_0 && ram_wr_en) begin
            ram[ram_addr_0] <= ram_data_in;
        end
    end
    assign ram_data_out_0 = ram[ram_addr_0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Transaction-level model: grant at edge e -> access in cycle e, ack in
    // cycle e+1, next arbitration no earlier than edge e+3.
    logic [DW-1:0] ref_mem [0:WORDS-1];
    int            pref      = 0;
    int            next_free = 0;
    bit            act       = 1'b0;
    int            acc_c     = -10;
    int            ack_c     = -10;
    int            win       = 0;
    bit            t_we      = 1'b0;
    logic [AW-1:0] t_addr    = '0;
    logic [DW-1:0] t_wdata   = '0;
    logic [DW-1:0] exp_rdata = '0;
    bit            rand_mode = 1'b0;
    bit            hold_mode = 1'b0;
    int            grants[$];

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b11) begin
`ifdef DPRAM_ARB_FIXED_PRIO_EN
            return 0;
`else
            return pref;
`endif
        end
        return r[1] ? 1 : 0;
    endfunction

    task automatic predict();
        int e = cyc + 1;
        if (rst) begin
            act       = 1'b0;
            pref      = 0;
            next_free = e + 1;
            exp_rdata = '0;
        end else begin
            if (act && e == acc_c + 1 && t_we && int'(t_addr) < DEPTH) ref_mem[t_addr] = t_wdata;
            if (e >= next_free && req != 2'b00) begin
                win       = pick(req);
                pref      = 1 - win;
                act       = 1'b1;
                acc_c     = e;
                ack_c     = e + 1;
                next_free = e + 3;
                t_we      = we[win];
                t_addr    = addr[win*AW +: AW];
                t_wdata   = wdata[win*DW +: DW];
            end
        end
    endtask

    task automatic check();
        bit         acc = act && cyc == acc_c && !rst;
        bit         inr = int'(t_addr) < DEPTH;
        logic [1:0] ea  = (act && cyc == ack_c) ? 2'(1 << win) : 2'b00;
        chk("ack", 32'(ack), 32'(ea));
        chk("ram_port_en_0", 32'(ram_port_en_0), 32'(acc && inr));
        chk("ram_wr_en", 32'(ram_wr_en), 32'(acc && inr && t_we));
        chk("ram_addr_0", 32'(ram_addr_0), acc ? 32'(t_addr) : 32'd0);
        chk("ram_data_in", 32'(ram_data_in), acc ? 32'(t_wdata) : 32'd0);
        if (act && cyc == ack_c && !t_we) exp_rdata = inr ? ref_mem[t_addr] : '0;
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        if (ack != 2'b00) grants.push_back(ack[1] ? 1 : 0);
    endtask

    task automatic start(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[i]              = w;
        addr[i*AW +: AW]   = a;
        wdata[i*DW +: DW]  = d;
        req[i]             = 1'b1;
    endtask

    task automatic tick();
        bit [1:0] dropped = '0;
        predict();
        @(negedge clk);
        check();
        for (int i = 0; i < 2; i++) begin
            if (!hold_mode && act && cyc == ack_c && win == i) begin
                req[i]     = 1'b0;
                dropped[i] = 1'b1;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] && !dropped[i] && $urandom_range(0, 2) == 0)
                    start(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, WORDS-1)), DW'($urandom));
            end
        end
    endtask

    task automatic wait_ack(input int i, input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (ack[i] !== 1'b1 && n < 8);
        chk({tag, "_ack"}, 32'(ack[i]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
        repeat (3) tick();
        rst      = 1'b0;
        ram_init = 1'b0;

        // Single write, fixed latency from the sampling edge.
        start(0, 1'b1, 4'd3, 8'hA5);
        tick();
        chk("wr_en_n1", 32'(ram_wr_en), 32'd1);
        chk("wr_addr_n1", 32'(ram_addr_0), 32'd3);
        tick();
        chk("wr_ack_n2", 32'(ack), 32'h1);

        // Read-back by requester 1.
        start(1, 1'b0, 4'd3, 8'h00);
        wait_ack(1, "rb");
        chk("rb_rdata", 32'(rdata), 32'hA5);

        // Out-of-range read returns zero.
        start(0, 1'b0, 4'd13, 8'h00);
        wait_ack(0, "oor");
        chk("oor_rdata", 32'(rdata), 32'd0);

        // Reset landing in SERVE kills the write and the ack.
        repeat (2) tick();
        start(0, 1'b1, 4'd5, 8'h3C);
        begin
            int n = 0;
            do begin
                tick();
                n++;
            end while (ram_port_en_0 !== 1'b1 && n < 6);
        end
        chk("rst_setup_wr", 32'(ram_wr_en), 32'd1);
        rst = 1'b1;
        req = '0;
        #1;
        chk("rst_gate_en", 32'(ram_port_en_0), 32'd0);
        chk("rst_gate_wr", 32'(ram_wr_en), 32'd0);
        tick();
        chk("rst_no_ack", 32'(ack), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        start(1, 1'b0, 4'd5, 8'h00);
        wait_ack(1, "rst_rb");
        chk("rst_rb_old", 32'(rdata), 32'(ref_mem[5]));

        // Continuous contention straight out of reset.
        rst = 1'b1;
        req = '0;
        repeat (2) tick();
        rst = 1'b0;
        grants.delete();
        hold_mode = 1'b1;
        start(0, 1'b0, 4'd1, 8'h00);
        start(1, 1'b0, 4'd2, 8'h00);
        repeat (14) tick();
        hold_mode = 1'b0;
        req = '0;
        repeat (4) tick();
        chk("rr_count", 32'(grants.size() >= 4), 32'd1);
        for (int k = 0; k < 4 && k < grants.size(); k++) begin
`ifdef DPRAM_ARB_FIXED_PRIO_EN
            chk("rr_order", 32'(grants[k]), 32'd0);
`else
            chk("rr_order", 32'(grants[k]), 32'(k % 2));
`endif
        end

        // Random traffic, including out-of-range addresses.
        rand_mode = 1'b1;
        repeat (600) tick();
        rand_mode = 1'b0;
        repeat (12) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 SHALL have parameter data_width, default 8, RAM word width in bits.
REQ-002 SHALL have parameter addr_width, default 4, RAM address width in bits.
REQ-003 SHALL have parameter depth, default 16, number of valid RAM words, at most 2**addr_width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  2  per-requester access request, bit i for requester i.
REQ-007 SHALL have port we  input  2  per-requester write (1) or read (0) select.
REQ-008 SHALL have port addr  input  2*addr_width  per-requester address; slice i belongs to requester i.
REQ-009 SHALL have port wdata  input  2*data_width  per-requester write data; slice i belongs to requester i.
REQ-010 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-011 SHALL have port rdata  output  data_width  read result, valid in the ack cycle.
REQ-012 SHALL have ports ram_port_en_0, ram_wr_en  output  1 each  RAM port-0 enable and write enable.
REQ-013 SHALL have ports ram_addr_0  output  addr_width, ram_data_in  output  data_width  RAM port-0 address and write data.
REQ-014 SHALL have port ram_data_out_0  input  data_width  RAM port-0 asynchronous read data.

Function
REQ-015 SHALL implement FSM IDLE -> SERVE -> DONE -> IDLE; arbitration occurs only in IDLE.
REQ-016 In IDLE with req != 0, SHALL pick one winner, latch its we/addr/wdata and index, and go to SERVE; with req == 0, SHALL stay in IDLE.
REQ-017 When both requesters request, round-robin SHALL grant the requester that did not win last; the pointer SHALL update only on a grant.
REQ-018 In SERVE, SHALL drive ram_port_en_0=1, ram_addr_0 and ram_data_in from the latched values, and ram_wr_en equal to the latched we.
REQ-019 On a read, SHALL capture ram_data_out_0 into rdata at the SERVE->DONE edge.
REQ-020 In DONE, SHALL assert ack for the winner only, for exactly one cycle, and then return to IDLE.
REQ-021 Latency SHALL be: req sampled at edge N, RAM access in cycle N+1, ack in cycle N+2; one access per 3 cycles maximum.
REQ-022 Requesters SHALL hold req, we, addr and wdata stable until ack and drop req in the ack cycle; a req still high in IDLE SHALL be re-arbitrated as a new request.
REQ-023 A latched addr >= depth SHALL suppress ram_port_en_0 and ram_wr_en, still produce an ack, and return rdata = 0.
REQ-024 rdata SHALL hold its last value outside the ack cycle, except on reset.
REQ-025 Outside SERVE, all ram_* outputs SHALL be 0.
REQ-026 RAM port 1 SHALL NOT be driven or observed by this block.

Reset
REQ-027 On rst: state SHALL be IDLE, round-robin pointer SHALL favour requester 0, and ack, rdata and all ram_* outputs SHALL be 0.
REQ-028 rst high during SERVE SHALL gate ram_wr_en and ram_port_en_0 to 0 in that cycle, so no write occurs; the in-flight access SHALL be dropped with no ack.

Configuration
REQ-029 With macro DPRAM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL always win contention and the pointer SHALL be removed; without it, REQ-017 round-robin SHALL apply.

Structure
REQ-030 Package dpram_arb_pkg SHALL hold the FSM state enum (IDLE, SERVE, DONE) and the default width and depth constants.
REQ-031 Winner selection SHALL be a sub-module dpram_rr_pick: inputs req and pointer, outputs a one-hot grant.

Verification
REQ-032 Single write: req=01, we=01, addr0=3, wdata0=0xA5 -> ram_wr_en=1 with ram_addr_0=3 in cycle N+1; ack=01 in N+2.
REQ-033 Read-back: after REQ-032, requester 1 reads addr 3 -> ack=10 and rdata=0xA5 in the ack cycle.
REQ-034 Contention: req=11 held continuously after reset -> grant order 0,1,0,1; with DPRAM_ARB_FIXED_PRIO_EN -> always 0.
REQ-035 Out of range: depth=12, read addr 13 -> no RAM enable, ack pulses, rdata=0.
REQ-036 Reset mid-SERVE: write 0x3C to addr 5 with rst high in SERVE -> no write, no ack, state IDLE; a later read of addr 5 returns the old value.
